// File: rtl/o_serdes_mc.sv
// Bonded multi-channel output serializer: per-word FIFO of {OE, data}, one shared
// controller, SDR (1 bit) or DDR (2 bits, upper bit first) per channel per clock.
module o_serdes_mc #(
    parameter int  WIDTH      = 4,
    parameter int  NUM_CH     = 4,
    parameter      DATA_RATE  = "SDR",
    parameter int  MSB_FIRST  = 1,
    parameter int  FIFO_DEPTH = 2,
    localparam int BPC        = (DATA_RATE == "DDR") ? 2 : 1
) (
    input  logic                    CLK_IN,
    input  logic                    RST,
    input  logic [NUM_CH*WIDTH-1:0] D,
    input  logic                    OE_IN,
    input  logic                    D_VALID,
    output logic                    D_READY,
    input  logic                    PLL_LOCK,
    input  logic                    CHANNEL_BOND_SYNC_IN,
    output logic                    CHANNEL_BOND_SYNC_OUT,
    output logic [NUM_CH*BPC-1:0]   Q,
    output logic                    OE_OUT,
    output logic                    UNDERRUN,
    input  logic                    UNDERRUN_CLR
);

    localparam int SLOTS  = WIDTH / BPC;
    localparam int DW     = NUM_CH * WIDTH;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DW:0]             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [SLOT_W-1:0]       r_slot;
    logic [DW-1:0]           r_shift;
    logic [NUM_CH*BPC-1:0]   r_q;
    logic                    r_oe;
    logic                    r_sync;
    logic                    r_underrun;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_has_data;
    logic                    w_start;
    logic                    w_boundary;
    logic                    w_load;
    logic                    w_load_oe;
    logic [DW:0]             w_head;
    logic [DW-1:0]           w_load_word;
    logic [DW-1:0]           w_ordered;
    logic [DW-1:0]           w_src;
    logic [DW-1:0]           w_shift_next;
    logic [NUM_CH*BPC-1:0]   w_q_next;

    assign D_READY     = (r_count < DEPTH_CNT) && !RST;
    assign w_has_data  = (r_count != '0);
    assign w_push      = D_VALID && D_READY;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_load      = w_start || w_boundary;
    assign w_pop       = w_load && w_has_data;
    assign w_load_oe   = w_has_data && w_head[DW];
    assign w_load_word = w_has_data ? w_head[DW-1:0] : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_boundary   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (PLL_LOCK && CHANNEL_BOND_SYNC_IN && w_has_data) begin
                    w_start      = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN:   w_boundary = PLL_LOCK && (r_slot == LAST_SLOT);
            default: w_state_next = S_IDLE;
        endcase
        if (!PLL_LOCK) begin
            w_state_next = S_IDLE;
        end
    end

    // Shifters hold each channel's word in transmit order, earliest bit at index 0.
    always_comb begin
        w_ordered    = '0;
        w_q_next     = '0;
        w_shift_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_ordered[c*WIDTH + i] = (MSB_FIRST != 0) ? w_load_word[c*WIDTH + WIDTH-1-i]
                                                          : w_load_word[c*WIDTH + i];
            end
        end
        w_src = w_load ? w_ordered : r_shift;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < BPC; k++) begin
                w_q_next[c*BPC + BPC-1-k] = w_src[c*WIDTH + k];
            end
            for (int i = 0; i < WIDTH - BPC; i++) begin
                w_shift_next[c*WIDTH + i] = w_src[c*WIDTH + i + BPC];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST || !PLL_LOCK) begin
            r_slot  <= '0;
            r_shift <= '0;
            r_q     <= '0;
            r_oe    <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_sync <= w_load;
            if (w_load) begin
                r_slot  <= '0;
                r_q     <= w_q_next;
                r_shift <= w_shift_next;
                r_oe    <= w_load_oe;
            end else if (r_state == S_RUN) begin
                r_slot  <= r_slot + 1'b1;
                r_q     <= w_q_next;
                r_shift <= w_shift_next;
            end
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST || !PLL_LOCK) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: word storage is not reset; the pointers and count alone define its contents.
    always_ff @(posedge CLK_IN) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {OE_IN, D};
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_underrun <= 1'b0;
        end else if (UNDERRUN_CLR) begin
            r_underrun <= 1'b0;
        end else if (w_boundary && !w_has_data) begin
            r_underrun <= 1'b1;
        end
    end

    assign Q                     = r_q;
    assign OE_OUT                = r_oe;
    assign CHANNEL_BOND_SYNC_OUT = r_sync;
    assign UNDERRUN              = r_underrun;

endmodule

// File: tb/tb_o_serdes_mc.sv
// Randomized bench for o_serdes_mc: an SDR instance tracked every cycle by a queue-based
// word model, and a DDR instance checked against per-slot bit arithmetic.
module tb_o_serdes_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // SDR instance: WIDTH=4, NUM_CH=2, MSB first, depth 2
    logic       s_rst, s_oe_in, s_valid, s_pll, s_sync_in, s_clr;
    logic [7:0] s_d;
    logic       s_ready, s_sync_out, s_oe_out, s_underrun;
    logic [1:0] s_q;

    // DDR instance: WIDTH=6, NUM_CH=1, LSB first, depth 2
    logic       d_rst, d_oe_in, d_valid, d_pll, d_sync_in, d_clr;
    logic [5:0] d_d;
    logic       d_ready, d_sync_out, d_oe_out, d_underrun;
    logic [1:0] d_q;

    o_serdes_mc #(.WIDTH(4), .NUM_CH(2), .DATA_RATE("SDR"), .MSB_FIRST(1), .FIFO_DEPTH(2)) dut_sdr (
        .CLK_IN(clk), .RST(s_rst), .D(s_d), .OE_IN(s_oe_in), .D_VALID(s_valid), .D_READY(s_ready),
        .PLL_LOCK(s_pll), .CHANNEL_BOND_SYNC_IN(s_sync_in), .CHANNEL_BOND_SYNC_OUT(s_sync_out),
        .Q(s_q), .OE_OUT(s_oe_out), .UNDERRUN(s_underrun), .UNDERRUN_CLR(s_clr)
    );

    o_serdes_mc #(.WIDTH(6), .NUM_CH(1), .DATA_RATE("DDR"), .MSB_FIRST(0), .FIFO_DEPTH(2)) dut_ddr (
        .CLK_IN(clk), .RST(d_rst), .D(d_d), .OE_IN(d_oe_in), .D_VALID(d_valid), .D_READY(d_ready),
        .PLL_LOCK(d_pll), .CHANNEL_BOND_SYNC_IN(d_sync_in), .CHANNEL_BOND_SYNC_OUT(d_sync_out),
        .Q(d_q), .OE_OUT(d_oe_out), .UNDERRUN(d_underrun), .UNDERRUN_CLR(d_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;
    string phase = "reset";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s.%s: got %0d expected %0d", phase, tag, obs, exp);
    endtask

    // Word-level model of the SDR instance
    typedef struct packed { logic oe; logic [7:0] d; } word_t;
    word_t m_fifo[$];
    word_t m_cur;
    bit    m_run, m_sync, m_under;
    int    m_slot;

    task automatic model_reset();
        m_fifo.delete();
        m_cur   = '0;
        m_run   = 1'b0;
        m_sync  = 1'b0;
        m_under = 1'b0;
        m_slot  = 0;
    endtask

    task automatic model_step();
        bit    push, under_set;
        word_t w;
        push      = s_valid && (m_fifo.size() < 2);
        under_set = 1'b0;
        if (!s_pll) begin
            m_fifo.delete();
            m_cur  = '0;
            m_run  = 1'b0;
            m_sync = 1'b0;
            m_slot = 0;
        end else begin
            if ((!m_run && s_sync_in && m_fifo.size() > 0) || (m_run && m_slot == 3)) begin
                if (m_fifo.size() > 0) m_cur = m_fifo.pop_front();
                else begin
                    m_cur     = '0;
                    under_set = 1'b1;
                end
                m_run  = 1'b1;
                m_slot = 0;
                m_sync = 1'b1;
            end else begin
                m_sync = 1'b0;
                if (m_run) m_slot++;
            end
            if (push) begin
                w.oe = s_oe_in;
                w.d  = s_d;
                m_fifo.push_back(w);
            end
        end
        if (s_clr) m_under = 1'b0;
        else if (under_set) m_under = 1'b1;
    endtask

    // Bit of channel c at slot s is data bit (3 - s) of that channel's nibble
    function automatic logic [31:0] exp_q();
        logic [31:0] r;
        r = '0;
        if (m_run) begin
            for (int c = 0; c < 2; c++) r[c] = m_cur.d[c*4 + 3 - m_slot];
        end
        return r;
    endfunction

    // LSB-first DDR: slot s carries bits 2s (earlier, upper Q bit) and 2s+1
    function automatic logic [31:0] ddr_pair(input logic [5:0] w, input int slot);
        logic [31:0] r;
        r    = '0;
        r[1] = w[2*slot];
        r[0] = w[2*slot + 1];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("q",    32'(s_q),        exp_q());
        check("oe",   32'(s_oe_out),   m_run ? 32'(m_cur.oe) : 32'd0);
        check("sync", 32'(s_sync_out), 32'(m_sync));
        check("undr", 32'(s_underrun), 32'(m_under));
        check("rdy",  32'(s_ready),    (m_fifo.size() < 2) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_b [4];
        logic [5:0] prev, nw;
        logic       prev_oe;
        int         sent;
        bit         acc;

        s_rst = 1'b1; s_oe_in = 1'b0; s_valid = 1'b0; s_pll = 1'b0; s_sync_in = 1'b0; s_clr = 1'b0; s_d = '0;
        d_rst = 1'b1; d_oe_in = 1'b0; d_valid = 1'b0; d_pll = 1'b0; d_sync_in = 1'b0; d_clr = 1'b0; d_d = '0;
        model_reset();

        #2;
        check("q",     32'(s_q),        32'd0);
        check("oe",    32'(s_oe_out),   32'd0);
        check("sync",  32'(s_sync_out), 32'd0);
        check("undr",  32'(s_underrun), 32'd0);
        check("rdy",   32'(s_ready),    32'd0);
        check("d_rdy", 32'(d_ready),    32'd0);
        check("d_q",   32'(d_q),        32'd0);
        #10;
        s_rst = 1'b0;
        d_rst = 1'b0;
        #1;
        check("rdy_release",   32'(s_ready), 32'd1);
        check("d_rdy_release", 32'(d_ready), 32'd1);

        // Basic: ch1=A, ch0=5, MSB first
        phase = "basic";
        s_pll = 1'b1; s_d = 8'hA5; s_oe_in = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_sync_in = 1'b1;
        exp_b = '{2'd2, 2'd1, 2'd2, 2'd1};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bit",  32'(s_q),        32'(exp_b[i]));
            check("oe1",  32'(s_oe_out),   32'd1);
            check("sync", 32'(s_sync_out), (i == 0) ? 32'd1 : 32'd0);
        end
        tick();
        check("idle_q",    32'(s_q),        32'd0);
        check("idle_oe",   32'(s_oe_out),   32'd0);
        check("idle_undr", 32'(s_underrun), 32'd1);

        phase = "stream";
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        check("clr", 32'(s_underrun), 32'd0);
        sent = 0;
        s_valid = 1'b1; s_d = 8'($urandom_range(0, 255)); s_oe_in = 1'b0;
        for (int cyc = 0; cyc < 200 && sent < 8; cyc++) begin
            acc = s_ready;
            tick();
            if (acc) begin
                sent++;
                s_d     = 8'($urandom_range(0, 255));
                s_oe_in = sent[0];
            end
        end
        s_valid = 1'b0;
        check("sent", 32'(sent), 32'd8);
        repeat (16) tick();
        check("drained_undr", 32'(s_underrun), 32'd1);

        phase = "underrun";
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        s_d = 8'($urandom_range(0, 255)); s_oe_in = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (12) tick();
        check("set", 32'(s_underrun), 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        s_d = 8'($urandom_range(0, 255)); s_oe_in = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (8) tick();
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        check("clr", 32'(s_underrun), 32'd0);

        phase = "gating";
        s_pll = 1'b0;
        tick();
        check("q_off", 32'(s_q), 32'd0);
        s_pll = 1'b1; s_sync_in = 1'b0;
        s_d = 8'($urandom_range(0, 255)) | 8'h88; s_oe_in = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (3) begin
            tick();
            check("held_q",    32'(s_q),        32'd0);
            check("held_sync", 32'(s_sync_out), 32'd0);
        end
        s_sync_in = 1'b1;
        tick();
        check("start_sync", 32'(s_sync_out), 32'd1);
        check("start_oe",   32'(s_oe_out),   32'd1);
        check("start_q",    32'(s_q),        32'd3);
        tick();
        s_pll = 1'b0;
        tick();
        check("drop_q",   32'(s_q),      32'd0);
        check("drop_oe",  32'(s_oe_out), 32'd0);
        check("drop_rdy", 32'(s_ready),  32'd1);
        s_pll = 1'b1;
        repeat (3) begin
            tick();
            check("flushed_q", 32'(s_q), 32'd0);
        end

        phase = "async_rst";
        s_d = 8'hFF; s_oe_in = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        #3;
        s_rst = 1'b1;
        #1;
        check("q",    32'(s_q),        32'd0);
        check("oe",   32'(s_oe_out),   32'd0);
        check("sync", 32'(s_sync_out), 32'd0);
        check("undr", 32'(s_underrun), 32'd0);
        check("rdy",  32'(s_ready),    32'd0);
        #2;
        s_rst = 1'b0;
        model_reset();
        #1;
        check("rdy_after", 32'(s_ready), 32'd1);
        s_d = 8'($urandom_range(0, 255)); s_oe_in = 1'b0; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (6) tick();
        s_pll = 1'b0;
        tick();

        // DDR: directed word then random words queued one per word time
        phase = "ddr";
        prev = 6'b110010; prev_oe = 1'b1;
        d_pll = 1'b1; d_d = prev; d_oe_in = prev_oe; d_valid = 1'b1;
        tick();
        d_valid = 1'b0; d_sync_in = 1'b1;
        tick();
        check("s0",       32'(d_q),        ddr_pair(prev, 0));
        check("s0_const", 32'(d_q),        32'd1);
        check("sync",     32'(d_sync_out), 32'd1);
        check("oe",       32'(d_oe_out),   32'd1);
        for (int n = 0; n < 4; n++) begin
            nw = 6'($urandom_range(0, 63));
            d_d = nw; d_oe_in = n[0]; d_valid = 1'b1;
            tick();
            d_valid = 1'b0;
            check("s1",   32'(d_q),        ddr_pair(prev, 1));
            check("oe",   32'(d_oe_out),   32'(prev_oe));
            check("nosync", 32'(d_sync_out), 32'd0);
            if (n == 0) check("s1_const", 32'(d_q), 32'd0);
            tick();
            check("s2", 32'(d_q), ddr_pair(prev, 2));
            if (n == 0) check("s2_const", 32'(d_q), 32'd3);
            tick();
            check("s0",   32'(d_q),        ddr_pair(nw, 0));
            check("sync", 32'(d_sync_out), 32'd1);
            check("oe",   32'(d_oe_out),   32'(n[0]));
            prev = nw; prev_oe = n[0];
        end
        tick();
        check("s1", 32'(d_q), ddr_pair(prev, 1));
        tick();
        check("s2", 32'(d_q), ddr_pair(prev, 2));
        tick();
        check("idle_q",    32'(d_q),        32'd0);
        check("idle_oe",   32'(d_oe_out),   32'd0);
        check("idle_sync", 32'(d_sync_out), 32'd1);
        check("idle_undr", 32'(d_underrun), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
